wb_ctrl: RTL and testbench

WB_CTRL -- requirements
Module: wb_ctrl

---
 rtl/wb_ctrl.sv | 120 ++++++++++++
 tb/tb_wb_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_ctrl.sv
// Writeback controller: buffers ALU results in a small FIFO, arbitrates them against
// load results for the single register-file write port, and tracks pending writes.
module wb_ctrl #(
    parameter int ALU_Q_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic [2:0]  q_count
);

    // Depth is a power of two (2 or 4), so pointers wrap by natural overflow.
    localparam int          PW        = $clog2(ALU_Q_DEPTH);
    localparam logic [2:0]  DEPTH_C   = 3'(ALU_Q_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [4:0]    r_q_rd   [ALU_Q_DEPTH];
    logic [31:0]   r_q_data [ALU_Q_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [2:0]    r_count;
    logic [31:0]   r_busy;
    logic          r_wb_en;
    logic [4:0]    r_wb_rd;
    logic [31:0]   r_wb_data;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_mem_sel;
    logic          w_commit;
    logic [4:0]    w_c_rd;
    logic [31:0]   w_c_data;
    logic [31:0]   w_set;
    logic [31:0]   w_clr;
    logic [31:0]   w_busy_nxt;

    assign w_full    = (r_count == DEPTH_C);
    assign w_empty   = (r_count == 3'd0);
    assign alu_ready = !w_full;
    assign w_push    = alu_valid && !w_full;

    // Loads win unless the queue is full; a full queue drains its head first so ALU never deadlocks.
    assign w_mem_sel = mem_valid && !w_full;
    assign w_pop     = !w_empty && (w_full || !mem_valid);
    assign w_commit  = w_mem_sel || w_pop;
    assign mem_ready = !(w_full && mem_valid);

    always_comb begin
        w_c_rd   = r_q_rd[r_rd_ptr];
        w_c_data = r_q_data[r_rd_ptr];
        if (w_mem_sel) begin
            w_c_rd   = mem_rd;
            w_c_data = mem_data;
        end
    end

    always_comb begin
        w_set = 32'd0;
        w_clr = 32'd0;
        if (issue_valid) w_set = 32'd1 << issue_rd;
        if (w_commit)    w_clr = 32'd1 << w_c_rd;
        w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~32'd1;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_rd[r_wr_ptr]   <= alu_rd;
            r_q_data[r_wr_ptr] <= alu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= 3'd0;
            r_busy    <= 32'd0;
            r_wb_en   <= 1'b0;
            r_wb_rd   <= 5'd0;
            r_wb_data <= 32'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_push && !w_pop)      r_count <= r_count + 3'd1;
            else if (!w_push && w_pop) r_count <= r_count - 3'd1;
            r_busy  <= w_busy_nxt;
            r_wb_en <= w_commit && (w_c_rd != 5'd0);
            if (w_commit) begin
                r_wb_rd   <= w_c_rd;
                r_wb_data <= w_c_data;
            end
        end
    end

    assign wb_en    = r_wb_en;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;
    assign q_count  = r_count;
    assign rs1_busy = r_busy[rs1];
    assign rs2_busy = r_busy[rs2];

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl with hand-computed expectations (ALU_Q_DEPTH=2).
module tb_wb_ctrl;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [2:0]  q_count;

    int total;
    int bad;

    wb_ctrl #(.ALU_Q_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .q_count(q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_rd = 5'd0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1; alu_rd = rd; alu_data = d;
    endtask

    task automatic drive_mem(input logic [4:0] rd, input logic [31:0] d);
        mem_valid = 1'b1; mem_rd = rd; mem_data = d;
    endtask

    task automatic chk_wb(input string tag, input logic en, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, "_en"}, 32'(wb_en), 32'(en));
        if (en) begin
            chk({tag, "_rd"}, 32'(wb_rd), 32'(rd));
            chk({tag, "_data"}, wb_data, d);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        idle();
        rs1 = 5'd0; rs2 = 5'd0;
        rst_n = 1'b0;
        #12;
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_qcount", 32'(q_count), 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Load only: mark x5 busy, then a load to x5 writes back next cycle and clears it.
        issue_valid = 1'b1; issue_rd = 5'd5; rs1 = 5'd5; rs2 = 5'd6;
        tick();
        idle();
        chk("issue_busy5", 32'(rs1_busy), 32'd1);
        chk("rs2_idle", 32'(rs2_busy), 32'd0);
        drive_mem(5'd5, 32'hDEADBEEF);
        #1;
        chk("load_mem_ready", 32'(mem_ready), 32'd1);
        tick();
        idle();
        chk_wb("load_wb", 1'b1, 5'd5, 32'hDEADBEEF);
        chk("load_busy5_clr", 32'(rs1_busy), 32'd0);
        tick();
        chk("load_hold_en", 32'(wb_en), 32'd0);
        chk("load_hold_rd", 32'(wb_rd), 32'd5);
        chk("load_hold_data", wb_data, 32'hDEADBEEF);

        // Collision: ALU x7 queued, then a load x8 overtakes it.
        drive_alu(5'd7, 32'h11);
        tick();
        idle();
        chk("col_q1", 32'(q_count), 32'd1);
        chk("col_no_wb", 32'(wb_en), 32'd0);
        drive_mem(5'd8, 32'h22);
        #1;
        chk("col_mem_ready", 32'(mem_ready), 32'd1);
        tick();
        idle();
        chk_wb("col_load_wb", 1'b1, 5'd8, 32'h22);
        chk("col_q_still1", 32'(q_count), 32'd1);
        tick();
        chk_wb("col_alu_wb", 1'b1, 5'd7, 32'h11);
        chk("col_q0", 32'(q_count), 32'd0);

        // Queue full while loads stream: loads go first until full, then the head drains.
        drive_alu(5'd1, 32'hA1); drive_mem(5'd12, 32'hC0);
        tick();
        chk_wb("full_l12", 1'b1, 5'd12, 32'hC0);
        chk("full_q1", 32'(q_count), 32'd1);
        drive_alu(5'd2, 32'hA2); drive_mem(5'd13, 32'hC1);
        tick();
        idle();
        chk_wb("full_l13", 1'b1, 5'd13, 32'hC1);
        chk("full_q2", 32'(q_count), 32'd2);
        chk("full_alu_ready", 32'(alu_ready), 32'd0);
        drive_mem(5'd14, 32'hC2);
        #1;
        chk("full_mem_ready", 32'(mem_ready), 32'd0);
        tick();
        chk_wb("full_head1", 1'b1, 5'd1, 32'hA1);
        chk("full_q_after_pop", 32'(q_count), 32'd1);
        chk("full_mem_ready_back", 32'(mem_ready), 32'd1);
        tick();
        idle();
        chk_wb("full_l14", 1'b1, 5'd14, 32'hC2);
        // Push and pop together: count holds, pointer wraps, order kept.
        drive_alu(5'd3, 32'hA3);
        tick();
        idle();
        chk_wb("full_head2", 1'b1, 5'd2, 32'hA2);
        chk("pushpop_q1", 32'(q_count), 32'd1);
        tick();
        chk_wb("wrap_head3", 1'b1, 5'd3, 32'hA3);
        chk("wrap_q0", 32'(q_count), 32'd0);

        // Scoreboard race: set wins over a same-cycle clear.
        rs1 = 5'd9;
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        chk("race_busy9", 32'(rs1_busy), 32'd1);
        drive_mem(5'd9, 32'h99);
        tick();
        idle();
        chk_wb("race_wb9", 1'b1, 5'd9, 32'h99);
        chk("race_set_wins", 32'(rs1_busy), 32'd1);
        drive_mem(5'd9, 32'h98);
        tick();
        idle();
        chk("race_clr9", 32'(rs1_busy), 32'd0);
        rs1 = 5'd0;
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        idle();
        chk("x0_never_busy", 32'(rs1_busy), 32'd0);

        // x0 load is consumed silently while an ALU result is queued behind it.
        drive_alu(5'd4, 32'h44); drive_mem(5'd0, 32'h55);
        #1;
        chk("x0_mem_ready", 32'(mem_ready), 32'd1);
        tick();
        idle();
        chk("x0_no_wb", 32'(wb_en), 32'd0);
        chk("x0_q1", 32'(q_count), 32'd1);
        tick();
        chk_wb("x0_then_alu", 1'b1, 5'd4, 32'h44);

        // Reset mid-operation.
        rs1 = 5'd3;
        issue_valid = 1'b1; issue_rd = 5'd3;
        drive_alu(5'd5, 32'h55); drive_mem(5'd0, 32'h0);
        tick();
        idle();
        drive_alu(5'd6, 32'h66); drive_mem(5'd15, 32'hF0);
        tick();
        idle();
        chk("mid_q2", 32'(q_count), 32'd2);
        chk("mid_busy3", 32'(rs1_busy), 32'd1);
        chk("mid_wb_en", 32'(wb_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wb_en", 32'(wb_en), 32'd0);
        chk("arst_q0", 32'(q_count), 32'd0);
        chk("arst_alu_ready", 32'(alu_ready), 32'd1);
        chk("arst_busy3", 32'(rs1_busy), 32'd0);
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst_no_wb", 32'(wb_en), 32'd0);
        chk("post_rst_q0", 32'(q_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
